adc_capture_sequencer: RTL and testbench
========================================

Name: adc_capture_sequencer

Overview:
- Sequences ADC sample capture into the 64-bit-wide PIO capture RAM in the i_62clk domain.
- Takes the free-running sample stream, throttles it to one write every (throttle+1) cycles, and generates the RAM write port signals: write enable, address, data and byte-enable.
- Stops after a programmed depth and reports busy, done and sample count to the host-side logic.
- Replaces the ad-hoc throttle state machine used in bring-up benches.

Parameters:
- ADDR_W, 14, RAM address width; the maximum capture depth is 2^ADDR_W words.
- DATA_W, 64, sample/RAM data width; must be a multiple of 8.
- THR_W, 5, width of the throttle (inter-write wait) field.

Ports:
- i_62clk  in  1  capture clock; all logic is on its rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_start  in  1  start pulse; honoured only in IDLE.
- i_abort  in  1  abort; forces IDLE from any state.
- i_depth  in  ADDR_W  words to capture; 0 means 2^ADDR_W.
- i_throttle  in  THR_W  idle cycles between writes; 0 means back-to-back.
- i_adc_data  in  DATA_W  ADC sample.
- i_adc_valid  in  1  sample qualifier.
- o_wr_en  out  1  RAM write enable, one-cycle pulse per sample.
- o_wr_addr  out  ADDR_W  RAM write address.
- o_wr_data  out  DATA_W  RAM write data; 0 when o_wr_en=0.
- o_byteen  out  DATA_W/8  all ones when o_wr_en=1, else 0.
- o_busy  out  1  high while in WRITE or WAIT.
- o_done  out  1  sticky capture-complete flag.
- o_count  out  ADDR_W+1  words written in the current or last capture.

Behaviour:
- Reset (async, i_reset=1): state IDLE; all outputs 0; internal address, counter and latched config cleared.
- All outputs are registered.
- States: IDLE, WRITE, WAIT.
- IDLE:
  - On i_start=1 and i_abort=0: latch i_depth and i_throttle; clear the address, o_count and o_done; go to WRITE.
  - Any change to i_depth or i_throttle after start is ignored until the next start.
- WRITE:
  - Waits indefinitely for i_adc_valid.
  - On the edge where i_adc_valid=1, register in one step:
    - o_wr_en=1
    - o_wr_data=i_adc_data
    - o_wr_addr=address
    - o_byteen=all ones
    - address+1, o_count+1
  - Latency is 1 cycle from the sampled valid to o_wr_en.
- After each write:
  - If o_count+1 equals the depth: go to IDLE, set o_done=1.
  - Else if throttle=0: stay in WRITE (a write is possible every cycle).
  - Else: go to WAIT with the wait counter at 0.
- WAIT:
  - o_wr_en=0; the counter increments each cycle.
  - When counter = throttle-1, go to WRITE.
  - Minimum write spacing is therefore throttle+1 cycles; samples arriving during WAIT are dropped.
- o_wr_en, o_wr_data and o_byteen return to 0 on the cycle after every write pulse.
- Depth 0 captures 2^ADDR_W words; the last address is 2^ADDR_W-1 and o_count reaches 2^ADDR_W (hence ADDR_W+1 bits).
- Abort:
  - i_abort=1 in any state: next edge goes to IDLE with o_wr_en=0 and o_done left 0.
  - o_count and o_wr_addr freeze at their last values.
  - A write in the same cycle as abort is suppressed.
- Start and abort together in IDLE: abort wins, no capture.
- i_start while busy is ignored.
- Reset mid-capture: immediate async clear to reset values; no partial write pulse.

Optional Feature:
- Macro: ADC_CAPTURE_RING_EN.
- When defined:
  - Adds input i_ring (1 bit, latched at start) and output o_wrapped (1 bit, sticky, cleared at start and reset).
  - With i_ring=1, reaching depth does not finish the capture: the address wraps to 0, o_wrapped is set, and o_count saturates at depth.
  - Capture continues until i_abort.
  - In ring mode an abort sets o_done=1, because the buffer holds valid data.
  - i_ring=0 behaves exactly as the base block.
- When undefined: i_ring and o_wrapped do not exist; behaviour is base only.

Test Plan:
- Reset, then start with depth=4, throttle=0, valid held high, data=cycle index → 4 consecutive o_wr_en pulses at addr 0,1,2,3, o_byteen=8'hFF during them, then o_done=1, o_busy=0, o_count=4.
- Depth=3, throttle=10, valid always high → write pulses exactly 11 cycles apart, addr 0..2, o_wr_data=0 and o_byteen=0 between pulses.
- Valid toggled (low 5 cycles, high 1), depth=2, throttle=0 → writes only on valid cycles; o_busy stays high until the second write.
- Abort asserted 2 cycles after the second write of a depth=8 run → IDLE, o_done=0, o_count=2; a following start with depth=1 writes addr 0 and sets o_done.
- Start and abort in the same cycle, and start while busy → no state change, no extra write.
- With ADC_CAPTURE_RING_EN, i_ring=1, depth=4 → addresses 0,1,2,3,0,1, o_wrapped=1 after the 4th write; abort → o_done=1, o_count=4.

Source files
------------

// File: rtl/adc_capture_sequencer.sv
// adc_capture_sequencer
//
// Sequences ADC samples into the 64-bit PIO capture RAM. After a start pulse,
// each qualified sample becomes one RAM write. Consecutive writes are spaced by
// at least (throttle+1) cycles. The capture stops after the programmed depth,
// or when the host aborts. All logic runs on the rising edge of i_62clk.
//
// Optional feature (macro ADC_CAPTURE_RING_EN):
//   Adds i_ring and o_wrapped. With i_ring=1 latched at start, the capture
//   runs as a ring buffer. It wraps to address 0 at the programmed depth and
//   continues until it is aborted.
//
// Ports:
//   i_62clk      capture clock
//   i_reset      asynchronous active-high reset
//   i_start      start pulse, honoured only when idle
//   i_abort      abort, returns to idle from any state
//   i_depth      words to capture (0 = 2^ADDR_W)
//   i_throttle   idle cycles between writes (0 = back-to-back)
//   i_adc_data   ADC sample
//   i_adc_valid  sample qualifier
//   i_ring       (ring build only) ring-buffer mode, latched at start
//   o_wrapped    (ring build only) sticky: the ring has wrapped at least once
//   o_wr_en      RAM write enable, one-cycle pulse per sample
//   o_wr_addr    RAM write address (holds the last written address)
//   o_wr_data    RAM write data, 0 outside write pulses
//   o_byteen     byte enables, all ones during write pulses
//   o_busy       capture in progress
//   o_done       sticky capture-complete flag
//   o_count      words written in the current or last capture
module adc_capture_sequencer #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 64,
    parameter int THR_W  = 5
) (
    input  logic                i_62clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic [ADDR_W-1:0]   i_depth,
    input  logic [THR_W-1:0]    i_throttle,
    input  logic [DATA_W-1:0]   i_adc_data,
    input  logic                i_adc_valid,
`ifdef ADC_CAPTURE_RING_EN
    input  logic                i_ring,
    output logic                o_wrapped,
`endif
    output logic                o_wr_en,
    output logic [ADDR_W-1:0]   o_wr_addr,
    output logic [DATA_W-1:0]   o_wr_data,
    output logic [DATA_W/8-1:0] o_byteen,
    output logic                o_busy,
    output logic                o_done,
    output logic [ADDR_W:0]     o_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [THR_W-1:0]  THR_ONE   = {{(THR_W-1){1'b0}}, 1'b1};
    // A programmed depth of 0 stands for a full 2^ADDR_W word capture.
    localparam logic [ADDR_W:0]   FULL_DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t             state;
    logic [ADDR_W-1:0]  addr;
    logic [ADDR_W:0]    depth_lat;
    logic [THR_W-1:0]   thr_lat;
    logic [THR_W-1:0]   wait_cnt;
    logic               ring_mode;

    logic [ADDR_W:0]    count_inc;
    logic [ADDR_W:0]    addr_inc;
    logic               last_word;
    logic               wrap_point;

`ifdef ADC_CAPTURE_RING_EN
    logic               ring_lat;
    assign ring_mode = ring_lat;
`else
    assign ring_mode = 1'b0;
`endif

    assign count_inc  = o_count + COUNT_ONE;
    assign addr_inc   = {1'b0, addr} + COUNT_ONE;
    // The write now being made is the last word of the programmed depth.
    assign last_word  = (count_inc == depth_lat);
    // The write now being made targets the last address of the buffer.
    assign wrap_point = (addr_inc == depth_lat);

    always_ff @(posedge i_62clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= IDLE;
            addr      <= '0;
            depth_lat <= '0;
            thr_lat   <= '0;
            wait_cnt  <= '0;
            o_wr_en   <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
            o_byteen  <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_count   <= '0;
`ifdef ADC_CAPTURE_RING_EN
            ring_lat  <= 1'b0;
            o_wrapped <= 1'b0;
`endif
        end else begin
            // Write strobes are single-cycle by default.
            o_wr_en   <= 1'b0;
            o_wr_data <= '0;
            o_byteen  <= '0;

            if (i_abort) begin
                // Abort overrides everything, including a start in IDLE or a
                // write in this cycle. A ring capture holds valid data, so an
                // abort there counts as completion.
                if (state != IDLE && ring_mode) begin
                    o_done <= 1'b1;
                end
                state  <= IDLE;
                o_busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_start) begin
                            depth_lat <= (i_depth == '0) ? FULL_DEPTH : {1'b0, i_depth};
                            thr_lat   <= i_throttle;
                            addr      <= '0;
                            o_count   <= '0;
                            o_done    <= 1'b0;
                            wait_cnt  <= '0;
                            o_busy    <= 1'b1;
                            state     <= WRITE;
`ifdef ADC_CAPTURE_RING_EN
                            ring_lat  <= i_ring;
                            o_wrapped <= 1'b0;
`endif
                        end
                    end

                    WRITE: begin
                        if (i_adc_valid) begin
                            o_wr_en   <= 1'b1;
                            o_wr_data <= i_adc_data;
                            o_wr_addr <= addr;
                            o_byteen  <= '1;
                            wait_cnt  <= '0;
                            // In ring mode the address wraps at the depth.
                            // Outside ring mode the capture ends there.
                            addr      <= wrap_point ? '0 : (addr + ADDR_ONE);
                            // The count saturates at depth, which only
                            // happens in ring mode.
                            if (o_count != depth_lat) begin
                                o_count <= count_inc;
                            end
`ifdef ADC_CAPTURE_RING_EN
                            if (ring_mode && wrap_point) begin
                                o_wrapped <= 1'b1;
                            end
`endif
                            if (last_word && !ring_mode) begin
                                state  <= IDLE;
                                o_done <= 1'b1;
                                o_busy <= 1'b0;
                            end else if (thr_lat == '0) begin
                                state <= WRITE;
                            end else begin
                                state <= WAIT;
                            end
                        end
                    end

                    WAIT: begin
                        // After WAIT cycles 0..throttle-1, the next edge
                        // returns to WRITE. This gives a spacing of
                        // throttle+1 cycles.
                        wait_cnt <= wait_cnt + THR_ONE;
                        if (wait_cnt == (thr_lat - THR_ONE)) begin
                            state <= WRITE;
                        end
                    end

                    default: begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_capture_sequencer.sv
module tb_adc_capture_sequencer;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 64;
    localparam int THR_W  = 5;
    localparam int FULL   = 1 << ADDR_W;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                abort;
    logic [ADDR_W-1:0]   depth;
    logic [THR_W-1:0]    thr;
    logic [DATA_W-1:0]   adata;
    logic                valid;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W/8-1:0] byteen;
    logic                busy;
    logic                done;
    logic [ADDR_W:0]     count;
`ifdef ADC_CAPTURE_RING_EN
    logic                ring;
    logic                wrapped;
`endif

    adc_capture_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .THR_W(THR_W)) dut (
        .i_62clk     (clk),
        .i_reset     (rst),
        .i_start     (start),
        .i_abort     (abort),
        .i_depth     (depth),
        .i_throttle  (thr),
        .i_adc_data  (adata),
        .i_adc_valid (valid),
`ifdef ADC_CAPTURE_RING_EN
        .i_ring      (ring),
        .o_wrapped   (wrapped),
`endif
        .o_wr_en     (wr_en),
        .o_wr_addr   (wr_addr),
        .o_wr_data   (wr_data),
        .o_byteen    (byteen),
        .o_busy      (busy),
        .o_done      (done),
        .o_count     (count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: capture progress expressed as words written and the
    // earliest edge at which the next write is allowed.
    bit                m_active, m_done, m_ring, m_wrapped;
    int                m_depth, m_thr, m_written, m_next_ok;
    int                k = 0;
    logic [ADDR_W-1:0] m_last_addr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_done = 0; m_ring = 0; m_wrapped = 0;
        m_depth = 0; m_thr = 0; m_written = 0; m_next_ok = 0;
        m_last_addr = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wr_en"}, 64'(wr_en), 0);
        chk({tag, "_addr"}, 64'(wr_addr), 0);
        chk({tag, "_data"}, wr_data, 0);
        chk({tag, "_byteen"}, 64'(byteen), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_count"}, 64'(count), 0);
`ifdef ADC_CAPTURE_RING_EN
        chk({tag, "_wrapped"}, 64'(wrapped), 0);
`endif
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic step(input bit st, input bit ab, input bit va, input logic [63:0] d,
                        input int dep, input int thr_in, input bit rg);
        bit          exp_en;
        logic [63:0] exp_data;
        int          exp_cnt;
        exp_en   = 0;
        exp_data = 0;
        start = st; abort = ab; valid = va; adata = d;
        depth = dep[ADDR_W-1:0];
        thr   = thr_in[THR_W-1:0];
`ifdef ADC_CAPTURE_RING_EN
        ring = rg;
`endif
        @(posedge clk);
        #1;
        k++;
        if (ab) begin
            if (m_active && m_ring) m_done = 1;
            m_active = 0;
        end else if (!m_active) begin
            if (st) begin
                m_active  = 1;
                m_done    = 0;
                m_written = 0;
                m_next_ok = k + 1;
                m_depth   = (dep % FULL == 0) ? FULL : dep % FULL;
                m_thr     = thr_in % (1 << THR_W);
                m_wrapped = 0;
`ifdef ADC_CAPTURE_RING_EN
                m_ring = rg;
`else
                m_ring = 0;
`endif
            end
        end else if (k >= m_next_ok && va) begin
            exp_en      = 1;
            exp_data    = d;
            m_last_addr = ADDR_W'(m_written % m_depth);
            m_written++;
            m_next_ok   = k + m_thr + 1;
            if (m_written >= m_depth) begin
                if (m_ring) m_wrapped = 1;
                else begin
                    m_active = 0;
                    m_done   = 1;
                end
            end
        end
        exp_cnt = (m_written > m_depth) ? m_depth : m_written;
        chk("wr_en", 64'(wr_en), 64'(exp_en));
        chk("wr_data", wr_data, exp_data);
        chk("byteen", 64'(byteen), exp_en ? 64'hFF : 64'h0);
        if (exp_en) chk("wr_addr", 64'(wr_addr), 64'(m_last_addr));
        chk("busy", 64'(busy), 64'(m_active));
        chk("done", 64'(done), 64'(m_done));
        chk("count", 64'(count), 64'(exp_cnt));
`ifdef ADC_CAPTURE_RING_EN
        chk("wrapped", 64'(wrapped), 64'(m_wrapped));
`endif
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        int dep, th;
        rst = 0; start = 0; abort = 0; valid = 0; adata = '0; depth = '0; thr = '0;
`ifdef ADC_CAPTURE_RING_EN
        ring = 0;
`endif
        model_reset();
        #1 rst = 1;
        #1 check_reset_outputs("reset");
        @(negedge clk) rst = 0;

        // Depth 4, back-to-back, data = cycle index.
        step(1, 0, 1, 64'(k), 4, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 64'(k + 1), 4, 0, 0);

        // Depth 3, throttle 10; config inputs change randomly after start.
        step(1, 0, 1, rnd64(), 3, 10, 0);
        for (int i = 0; i < 40; i++)
            step(0, 0, 1, rnd64(), $urandom_range(0, 50), $urandom_range(0, 31), 0);

        // Sparse valid: low 5 cycles, high 1; depth 2.
        step(1, 0, 0, rnd64(), 2, 0, 0);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 5; i++) step(0, 0, 0, rnd64(), 2, 0, 0);
            step(0, 0, 1, rnd64(), 2, 0, 0);
        end

        // Abort two cycles after the second write of a depth-8 run.
        step(1, 0, 0, rnd64(), 8, 0, 0);
        step(0, 0, 1, rnd64(), 8, 0, 0);
        step(0, 0, 1, rnd64(), 8, 0, 0);
        step(0, 0, 0, rnd64(), 8, 0, 0);
        step(0, 0, 0, rnd64(), 8, 0, 0);
        step(0, 1, 1, rnd64(), 8, 0, 0);
        chk("abort_addr_frozen", 64'(wr_addr), 1);
        step(0, 0, 1, rnd64(), 8, 0, 0);
        step(1, 0, 0, rnd64(), 1, 0, 0);
        step(0, 0, 1, rnd64(), 1, 0, 0);
        step(0, 0, 1, rnd64(), 1, 0, 0);

        // Start with abort in idle, then start held while busy.
        step(1, 1, 1, rnd64(), 5, 0, 0);
        step(0, 0, 1, rnd64(), 5, 0, 0);
        step(1, 0, 1, rnd64(), 3, 2, 0);
        for (int i = 0; i < 12; i++) step(1, 0, 1, rnd64(), 6, 0, 0);
        step(0, 0, 1, rnd64(), 6, 0, 0);

        // Randomised captures: depth, throttle, valid density and aborts.
        for (int c = 0; c < 25; c++) begin
            dep = $urandom_range(0, 3) == 0 ? 1 : $urandom_range(1, 40);
            th  = $urandom_range(0, 2) == 0 ? 0 : $urandom_range(0, 31);
            step(1, 0, $urandom_range(0, 1) == 1, rnd64(), dep, th, 0);
            for (int i = 0; i < 6000 && m_active; i++)
                step($urandom_range(0, 9) == 0, $urandom_range(0, 299) == 0,
                     $urandom_range(0, 3) != 0, rnd64(),
                     $urandom_range(0, 63), $urandom_range(0, 31), 0);
            chk("capture_ended", 64'(busy), 0);
            step(0, 0, 1, rnd64(), dep, th, 0);
        end

        // Depth 0 = full 2^ADDR_W capture, back-to-back.
        step(1, 0, 1, rnd64(), 0, 0, 0);
        for (int i = 0; i < FULL + 2; i++) step(0, 0, 1, rnd64(), 0, 0, 0);

        // Reset mid-capture clears asynchronously; no write afterwards.
        step(1, 0, 1, rnd64(), 10, 1, 0);
        step(0, 0, 1, rnd64(), 10, 1, 0);
        step(0, 0, 1, rnd64(), 10, 1, 0);
        rst = 1;
        #1 check_reset_outputs("midreset");
        model_reset();
        #1 rst = 0;
        for (int i = 0; i < 3; i++) step(0, 0, 1, rnd64(), 10, 1, 0);

`ifdef ADC_CAPTURE_RING_EN
        // Ring mode: depth 4 wraps, abort completes the capture.
        step(1, 0, 1, rnd64(), 4, 0, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 1, rnd64(), 4, 0, 0);
        step(0, 1, 1, rnd64(), 4, 0, 0);
        chk("ring_done", 64'(done), 1);
        chk("ring_count", 64'(count), 4);
        // Ring with throttle and sparse valid.
        step(1, 0, 0, rnd64(), 3, 2, 1);
        for (int i = 0; i < 60; i++) step(0, 0, $urandom_range(0, 1) == 1, rnd64(), 7, 0, 0);
        step(0, 1, 0, rnd64(), 3, 2, 0);
        // Ring input low behaves as the base block.
        step(1, 0, 1, rnd64(), 3, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, rnd64(), 3, 0, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
